annul_sequencer: RTL and testbench
==================================

# annul_sequencer

Per-thread annulment scheduler for the barrel-threaded datapath. It tracks the round-robin issue slot and, after a thread raises a flush (branch taken, cancelled instruction), drives the datapath's annul control for that thread's next N issue slots. Other threads are unaffected. It sits beside the thread-slot counter at the front of the pipeline and drives the annul input of the word-gating stages.

## Interface
Parameters:
- THREAD_COUNT, 8, number of hardware threads sharing the pipeline round-robin (≥2)
- THREAD_COUNT_WIDTH, 3, width of thread id, ≥ clog2(THREAD_COUNT)
- DEPTH_WIDTH, 3, width of per-thread pending-annul counter; max depth = 2^DEPTH_WIDTH−1

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  current-slot thread requests annulment of its following slots
- flush_depth  in  DEPTH_WIDTH  number of that thread's subsequent slots to annul (0 = none)
- thread_id  out  THREAD_COUNT_WIDTH  thread owning the current issue slot
- annul  out  1  1 = current slot's instruction must be gated to zero
- annul_pending  out  1  1 = any thread has a nonzero pending count

## Operation
- Slot counter: thread_id advances by 1 every cycle, wraps THREAD_COUNT−1 → 0; no stall input.
- Per-thread counter pending[t], DEPTH_WIDTH bits.
- annul = (pending[thread_id] != 0); annul_pending = OR over all pending[t] != 0. Both derived only from registered state; no combinational path from flush/flush_depth to any output.
- Update at each edge, for t = thread_id only (other threads hold):
  - annul=1: pending[t] ← pending[t]−1; flush ignored (annulled instruction cannot flush).
  - annul=0, flush=1: pending[t] ← flush_depth (load, no accumulation).
  - annul=0, flush=0: hold (already 0).
- flush with flush_depth=0: no effect.
- Counters never wrap below 0; decrement only when nonzero.
- Reset: thread_id=0, all pending=0, so annul=0, annul_pending=0 in the cycle after reset is sampled. Reset mid-sequence discards all pending annulment; reset has priority over flush.

## Timing
- Flush by thread t at cycle n (thread_id=t): annul=1 at cycles n+THREAD_COUNT, n+2·THREAD_COUNT, … for flush_depth slots; annul=0 at n+(flush_depth+1)·THREAD_COUNT.
- annul_pending rises at cycle n+1 and falls in the cycle after the last annulled slot of the last pending thread.
- Throughput: one flush accepted per cycle (one per thread per rotation). Flushes from different threads are fully independent.
- All outputs valid one cycle after reset deasserts; thread_id=0 in that cycle.

## Test plan
- Reset release, no flush -> thread_id cycles 0..7,0,…; annul=0 and annul_pending=0 for 32 cycles.
- Flush at thread_id=3, depth=2, cycle n -> annul=1 at n+8 and n+16 with thread_id=3; annul=0 at n+24; annul_pending=1 from n+1 through n+16, 0 at n+17; no other thread annulled.
- Flush at thread 3, depth=3, then flush=1 asserted on thread 3's annulled slot at n+8 with depth=7 -> ignored; annul on 3 ends after n+24; annul=0 at n+32.
- Flush thread 2 depth=1 and thread 5 depth=4 in the same rotation -> thread 2 annulled one slot, thread 5 four slots, independently; annul_pending stays 1 until thread 5's last annulled slot.
- Flush with depth=0 at thread 6 -> no annul anywhere; annul_pending remains 0.
- Flush thread 1 depth=7, assert reset for one cycle at n+10 -> next cycle thread_id=0, annul=0, annul_pending=0; thread 1 not annulled on its following slot.

Source files
------------

// File: rtl/annul_sequencer.sv
// Per-thread annulment scheduler: tracks the round-robin issue slot and gates
// the next N issue slots of any thread that raised a flush.
module annul_sequencer #(
    parameter int unsigned THREAD_COUNT       = 8,
    parameter int unsigned THREAD_COUNT_WIDTH = 3,
    parameter int unsigned DEPTH_WIDTH        = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [DEPTH_WIDTH-1:0]        flush_depth,
    output logic [THREAD_COUNT_WIDTH-1:0] thread_id,
    output logic                          annul,
    output logic                          annul_pending
);

    localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

    logic [THREAD_COUNT_WIDTH-1:0] thread_q, thread_d;
    logic [DEPTH_WIDTH-1:0]        pending_q [THREAD_COUNT];
    logic [DEPTH_WIDTH-1:0]        pending_d [THREAD_COUNT];
    logic [DEPTH_WIDTH-1:0]        cur_pending;
    logic                          any_pending;

    always_comb begin
        thread_d = (thread_q == LAST_THREAD) ? '0 : thread_q + THREAD_COUNT_WIDTH'(1);
    end

    // Only the slot owner's counter moves; an annulled slot cannot reload it.
    always_comb begin
        for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
            pending_d[t] = pending_q[t];
        end
        cur_pending = pending_q[thread_q];
        if (cur_pending != '0) begin
            pending_d[thread_q] = cur_pending - DEPTH_WIDTH'(1);
        end else if (flush) begin
            pending_d[thread_q] = flush_depth;
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
            any_pending = any_pending | (pending_q[t] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            thread_q <= '0;
            for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
                pending_q[t] <= '0;
            end
        end else begin
            thread_q <= thread_d;
            for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
                pending_q[t] <= pending_d[t];
            end
        end
    end

    assign thread_id     = thread_q;
    assign annul         = (cur_pending != '0);
    assign annul_pending = any_pending;

endmodule

// File: tb/tb_annul_sequencer.sv
// Self-checking bench for annul_sequencer: a schedule-based model predicts each
// cycle's outputs into a scoreboard queue; table vectors check annulled-slot counts.
module tb_annul_sequencer;

    localparam int T  = 8;
    localparam int TW = 3;
    localparam int DW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic [DW-1:0] flush_depth;
    logic [TW-1:0] thread_id;
    logic          annul;
    logic          annul_pending;

    always #5 clock = ~clock;

    annul_sequencer #(
        .THREAD_COUNT       (T),
        .THREAD_COUNT_WIDTH (TW),
        .DEPTH_WIDTH        (DW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .flush_depth   (flush_depth),
        .thread_id     (thread_id),
        .annul         (annul),
        .annul_pending (annul_pending)
    );

    typedef struct {
        int tid;
        bit annul;
        bit pend;
    } exp_t;

    typedef struct {
        int thr;
        int dep;
        int exp_slots;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[5];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tid_m  = 0;
    int f_cyc[T];
    int f_dep[T];
    int annul_cnt[T];

    // Thread t is annulled at cycle c if c is one of the d rotations after its flush.
    function automatic bit annul_exp(int t, int c);
        return f_dep[t] > 0 && c > f_cyc[t] && c <= f_cyc[t] + T * f_dep[t]
               && ((c - f_cyc[t]) % T) == 0;
    endfunction

    function automatic bit pend_exp(int c);
        bit p = 1'b0;
        for (int t = 0; t < T; t++)
            if (f_dep[t] > 0 && c > f_cyc[t] && c <= f_cyc[t] + T * f_dep[t]) p = 1'b1;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        for (int t = 0; t < T; t++) annul_cnt[t] = 0;
    endtask

    task automatic step(input bit rst, input bit fl, input int dep);
        exp_t e;
        reset       = rst;
        flush       = fl;
        flush_depth = dep[DW-1:0];
        if (rst) begin
            for (int t = 0; t < T; t++) f_dep[t] = 0;
            tid_m = 0;
        end else begin
            if (fl && dep != 0 && !annul_exp(tid_m, cyc)) begin
                f_cyc[tid_m] = cyc;
                f_dep[tid_m] = dep;
            end
            tid_m = (tid_m + 1) % T;
        end
        cyc++;
        e.tid   = tid_m;
        e.annul = annul_exp(tid_m, cyc);
        e.pend  = pend_exp(cyc);
        sbq.push_back(e);
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        check("thread_id", int'(thread_id), e.tid);
        check("annul", int'(annul), int'(e.annul));
        check("annul_pending", int'(annul_pending), int'(e.pend));
        if (annul === 1'b1) annul_cnt[thread_id]++;
    endtask

    task automatic align_to(input int thr);
        for (int k = 0; k < T && tid_m != thr; k++) step(0, 0, 0);
        check("align", tid_m, thr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{thr: 3, dep: 2, exp_slots: 2};
        vecs[1] = '{thr: 6, dep: 0, exp_slots: 0};
        vecs[2] = '{thr: 0, dep: 7, exp_slots: 7};
        vecs[3] = '{thr: 7, dep: 1, exp_slots: 1};
        vecs[4] = '{thr: 4, dep: 5, exp_slots: 5};
        for (int t = 0; t < T; t++) begin
            f_cyc[t] = 0;
            f_dep[t] = 0;
        end
        clear_counts();
        reset = 1'b1;
        flush = 1'b0;
        flush_depth = '0;

        step(1, 0, 0);
        step(1, 0, 0);
        idle(32);

        for (int i = 0; i < 5; i++) begin
            int others;
            align_to(vecs[i].thr);
            clear_counts();
            step(0, 1, vecs[i].dep);
            idle(T * 8 + T);
            check("vec_slots", annul_cnt[vecs[i].thr], vecs[i].exp_slots);
            others = 0;
            for (int t = 0; t < T; t++) if (t != vecs[i].thr) others += annul_cnt[t];
            check("vec_other_threads", others, 0);
        end

        // Flush raised on an already-annulled slot must be ignored.
        align_to(3);
        clear_counts();
        step(0, 1, 3);
        idle(T - 1);
        step(0, 1, 7);
        idle(T * 8);
        check("ignored_flush_slots", annul_cnt[3], 3);

        // Two independent flushes in the same rotation.
        align_to(2);
        clear_counts();
        step(0, 1, 1);
        idle(2);
        step(0, 1, 4);
        idle(T * 5 + T);
        check("indep_thr2_slots", annul_cnt[2], 1);
        check("indep_thr5_slots", annul_cnt[5], 4);

        // Reset mid-sequence discards pending annulment.
        align_to(1);
        clear_counts();
        step(0, 1, 7);
        idle(9);
        step(1, 0, 0);
        clear_counts();
        idle(2 * T);
        check("post_reset_thr1_slots", annul_cnt[1], 0);
        check("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
